distribute_1xn_cmd_flow_buf: RTL and testbench
==============================================

DISTRIBUTE_1XN_CMD_FLOW_BUF -- requirements
Module: distribute_1xn_cmd_flow_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload bits per word.
REQ-002 SHALL have parameter NUM_DATA_OUT, default 4, output ports; power of 2, >=2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, words buffered per output; >=1.
REQ-004 SHALL have parameter IN_COMMAND_WIDTH, default 6, input command bits.
REQ-005 SHALL have parameter CMD_MODE, default 0; 0 = binary tag (unicast), 1 = bitmask tag (multicast).
REQ-006 SHALL derive TAG_W = log2(NUM_DATA_OUT) in mode 0, NUM_DATA_OUT in mode 1; OUT_CMD_W = max(IN_COMMAND_WIDTH-TAG_W, 1).
REQ-007 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-008 SHALL have ports: i_en  in  1  switch enable; i_valid  in  1  input word valid; o_ready  out  1  switch can accept.
REQ-009 SHALL have ports: i_data_bus  in  DATA_WIDTH  input word; i_cmd  in  IN_COMMAND_WIDTH  tag in MSBs, remainder below.
REQ-010 SHALL have ports: o_valid  out  NUM_DATA_OUT; i_ready  in  NUM_DATA_OUT  downstream ready, one per port.
REQ-011 SHALL have ports: o_data_bus  out  NUM_DATA_OUT*DATA_WIDTH; o_cmd  out  NUM_DATA_OUT*OUT_CMD_W; port k at slice k (port 0 in LSBs).
REQ-012 SHALL have port o_err  out  1  one-cycle pulse on discarded word.

Function
REQ-013 SHALL decode i_cmd[IN-1 -: TAG_W] into target mask T: mode 0 one-hot of tag value; mode 1 tag bits directly.
REQ-014 SHALL forward i_cmd[OUT_CMD_W-1:0] unchanged with the word to every targeted port; if IN_COMMAND_WIDTH<=TAG_W, forwarded cmd is 0.
REQ-015 SHALL drive o_ready = i_en AND (every port in T has a free FIFO slot); combinational from i_cmd, FIFO state.
REQ-016 SHALL accept word when i_valid & o_ready; word written into all targeted FIFOs in that same edge (all-or-nothing multicast).
REQ-017 SHALL never write a partial multicast set; if any targeted FIFO is full, no FIFO is written, o_ready=0.
REQ-018 SHALL, when T==0 (mode 1 only) and i_valid & i_en, accept and discard the word, pulse o_err next cycle, write nothing.
REQ-019 SHALL present a word on port k (o_valid[k]=1) the cycle after acceptance when FIFO k was empty; latency 1 cycle.
REQ-020 SHALL pop FIFO k on o_valid[k] & i_ready[k]; o_data/o_cmd slice k hold stable while o_valid[k]=1 and i_ready[k]=0.
REQ-021 SHALL allow simultaneous pop and push on a full FIFO only via the next cycle (full FIFO reports not-free the same cycle; no combinational ready path from i_ready to o_ready).
REQ-022 SHALL keep per-port order FIFO; ports drain independently.
REQ-023 SHALL drive o_data/o_cmd slice k to 0 when o_valid[k]=0.
REQ-024 SHALL, when i_en=0, accept nothing but continue draining FIFOs.
REQ-025 SHALL keep FIFO pointers modulo FIFO_DEPTH with count register 0..FIFO_DEPTH for full/empty.

Reset
REQ-026 SHALL on rst=1 immediately clear all FIFO counts/pointers, o_valid=0, o_data_bus=0, o_cmd=0, o_err=0.
REQ-027 SHALL discard buffered words on reset mid-operation; first post-reset accept behaves as from empty.
REQ-028 SHALL drive o_ready=0 while rst=1.

Structure
REQ-029 SHALL place CMD_MODE encodings and TAG_W/OUT_CMD_W helper functions in shared package distribute_pkg.
REQ-030 SHALL instantiate NUM_DATA_OUT copies of sub-module dist_out_fifo (DATA_WIDTH+OUT_CMD_W wide, FIFO_DEPTH deep, push/pop/full/empty).
REQ-031 SHALL keep tag decode and all-or-nothing push logic in the top module.

Verification
REQ-032 Mode 0, N=4, i_cmd=6'b10_0101, data 0xA5 -> o_valid=4'b0100 next cycle, port 2 data 0xA5, cmd 4'b0101.
REQ-033 Mode 1, N=4, IN=6, i_cmd=6'b1011_01, all ready -> ports 0,1,3 valid next cycle same data, cmd 2'b01; port 2 idle.
REQ-034 Mode 1, port 3 FIFO full (i_ready[3]=0, DEPTH=2, two words), cmd mask 1001 -> o_ready=0, port 0 receives nothing; release i_ready[3] -> word delivered to both.
REQ-035 Mode 1, mask 0000, i_valid=1 -> accepted, o_err=1 one cycle, no o_valid.
REQ-036 Stream 3 words to port 1 with i_ready[1]=0, DEPTH=2 -> third stalls; assert rst mid-stream -> all o_valid=0 immediately, o_ready=1 after release.
REQ-037 i_en=0 with buffered words -> no accepts, buffered words still drain in order.

Source files
------------

// File: rtl/distribute_pkg.sv
// Shared command-mode encodings and width helpers for the 1xN distributor.
package distribute_pkg;

  localparam int CMD_MODE_BINARY = 0;  // tag is a binary port index (unicast)
  localparam int CMD_MODE_MASK   = 1;  // tag is a port bitmask (multicast)

  // Width of the tag field carried in the MSBs of the input command.
  function automatic int tag_width(input int cmd_mode, input int num_out);
    return (cmd_mode == CMD_MODE_MASK) ? num_out : $clog2(num_out);
  endfunction

  // Width of the command forwarded with each word; never narrower than one bit.
  function automatic int out_cmd_width(input int in_cmd_w, input int tag_w);
    return ((in_cmd_w - tag_w) > 1) ? (in_cmd_w - tag_w) : 1;
  endfunction

endpackage

// File: rtl/dist_out_fifo.sv
// Per-port output FIFO: circular buffer with an explicit occupancy count.
module dist_out_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Control state; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/distribute_1xn_cmd_flow_buf.sv
// 1-to-N command-tagged distributor with per-port buffering and
// all-or-nothing multicast acceptance.
module distribute_1xn_cmd_flow_buf
  import distribute_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_DATA_OUT     = 4,
  parameter int FIFO_DEPTH       = 2,
  parameter int IN_COMMAND_WIDTH = 6,
  parameter int CMD_MODE         = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_en,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [DATA_WIDTH-1:0]              i_data_bus,
  input  logic [IN_COMMAND_WIDTH-1:0]        i_cmd,
  output logic [NUM_DATA_OUT-1:0]            o_valid,
  input  logic [NUM_DATA_OUT-1:0]            i_ready,
  output logic [NUM_DATA_OUT*DATA_WIDTH-1:0] o_data_bus,
  output logic [NUM_DATA_OUT*out_cmd_width(IN_COMMAND_WIDTH,
                tag_width(CMD_MODE, NUM_DATA_OUT))-1:0] o_cmd,
  output logic                               o_err
);

  localparam int N         = NUM_DATA_OUT;
  localparam int TAG_W     = tag_width(CMD_MODE, NUM_DATA_OUT);
  localparam int OUT_CMD_W = out_cmd_width(IN_COMMAND_WIDTH, TAG_W);
  localparam int EW        = DATA_WIDTH + OUT_CMD_W;

  logic [TAG_W-1:0]     tag;
  logic [N-1:0]         tgt;
  logic [OUT_CMD_W-1:0] fwd_cmd;
  logic [N-1:0]         fifo_full;
  logic [N-1:0]         fifo_empty;
  logic [N-1:0]         fifo_push;
  logic [N-1:0]         fifo_pop;
  logic [EW-1:0]        fifo_dout [N];
  logic                 accept;
  logic                 err_q, err_d;

  assign tag = i_cmd[IN_COMMAND_WIDTH-1 -: TAG_W];

  generate
    if (CMD_MODE == CMD_MODE_MASK) begin : g_mask_decode
      assign tgt = tag;
    end else begin : g_bin_decode
      // Binary tag selects exactly one port.
      always_comb begin
        tgt      = '0;
        tgt[tag] = 1'b1;
      end
    end

    if (IN_COMMAND_WIDTH > TAG_W) begin : g_fwd_cmd
      assign fwd_cmd = i_cmd[OUT_CMD_W-1:0];
    end else begin : g_no_fwd_cmd
      assign fwd_cmd = '0;
    end
  endgenerate

  // Ready only if every targeted port has room; an empty mask is always
  // acceptable (the word is discarded). Full FIFOs stay not-free this cycle
  // even if they are being popped, so i_ready never reaches o_ready.
  assign o_ready   = i_en & ~rst & ~|(tgt & fifo_full);
  assign accept    = i_valid & o_ready;
  assign fifo_push = {N{accept}} & tgt;
  assign fifo_pop  = ~fifo_empty & i_ready;
  assign err_d     = accept & ~|tgt;
  assign o_err     = err_q;

  // Discard flag: one-cycle pulse after an untargeted word is swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_port
      dist_out_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push[k]),
        .din_i   ({fwd_cmd, i_data_bus}),
        .pop_i   (fifo_pop[k]),
        .dout_o  (fifo_dout[k]),
        .full_o  (fifo_full[k]),
        .empty_o (fifo_empty[k])
      );

      assign o_valid[k] = ~fifo_empty[k];
      assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] =
        o_valid[k] ? fifo_dout[k][DATA_WIDTH-1:0] : '0;
      assign o_cmd[k*OUT_CMD_W +: OUT_CMD_W] =
        o_valid[k] ? fifo_dout[k][EW-1:DATA_WIDTH] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_distribute_1xn_cmd_flow_buf.sv
// Bench for the 1xN distributor: a binary-tag instance (index 0) and a
// bitmask-tag instance (index 1), both N=4, DEPTH=2, IN=6, checked against
// a queue-based reference model.
module tb_distribute_1xn_cmd_flow_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         en_s    [2];
  logic         valid_s [2];
  logic [5:0]   cmd_s   [2];
  logic [31:0]  data_s  [2];
  logic [3:0]   rdy_s   [2];
  logic         ordy    [2];
  logic [3:0]   ovld    [2];
  logic [127:0] odata   [2];
  logic         oerr    [2];
  logic [15:0]  ocmd0;
  logic [7:0]   ocmd1;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: queue per (dut, port) of {cmd[3:0], data[31:0]}.
  logic [35:0] mq [8][$];
  bit          err_pend [2];

  distribute_1xn_cmd_flow_buf #(.DATA_WIDTH(32), .NUM_DATA_OUT(4), .FIFO_DEPTH(2),
    .IN_COMMAND_WIDTH(6), .CMD_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_en(en_s[0]), .i_valid(valid_s[0]), .o_ready(ordy[0]),
    .i_data_bus(data_s[0]), .i_cmd(cmd_s[0]), .o_valid(ovld[0]), .i_ready(rdy_s[0]),
    .o_data_bus(odata[0]), .o_cmd(ocmd0), .o_err(oerr[0]));

  distribute_1xn_cmd_flow_buf #(.DATA_WIDTH(32), .NUM_DATA_OUT(4), .FIFO_DEPTH(2),
    .IN_COMMAND_WIDTH(6), .CMD_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_en(en_s[1]), .i_valid(valid_s[1]), .o_ready(ordy[1]),
    .i_data_bus(data_s[1]), .i_cmd(cmd_s[1]), .o_valid(ovld[1]), .i_ready(rdy_s[1]),
    .o_data_bus(odata[1]), .o_cmd(ocmd1), .o_err(oerr[1]));

  function automatic logic [3:0] tmask(int d, logic [5:0] c);
    if (d == 0) return 4'b0001 << c[5:4];
    return c[5:2];
  endfunction

  function automatic logic [3:0] fwd(int d, logic [5:0] c);
    if (d == 0) return c[3:0];
    return {2'b00, c[1:0]};
  endfunction

  function automatic bit model_ready(int d);
    logic [3:0] m;
    m = tmask(d, cmd_s[d]);
    if (rst || !en_s[d]) return 1'b0;
    for (int k = 0; k < 4; k++)
      if (m[k] && mq[d*4+k].size() >= 2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mq[i].delete();
    err_pend[0] = 1'b0;
    err_pend[1] = 1'b0;
  endtask

  task automatic check_all();
    logic [3:0]   ev;
    logic [127:0] ed;
    logic [15:0]  ec;
    logic [15:0]  oc;
    for (int d = 0; d < 2; d++) begin
      ev = '0; ed = '0; ec = '0;
      for (int k = 0; k < 4; k++) begin
        if (mq[d*4+k].size() > 0) begin
          ev[k] = 1'b1;
          ed[k*32 +: 32] = mq[d*4+k][0][31:0];
          if (d == 0) ec[k*4 +: 4] = mq[d*4+k][0][35:32];
          else        ec[k*2 +: 2] = mq[d*4+k][0][33:32];
        end
      end
      oc = (d == 0) ? ocmd0 : {8'h00, ocmd1};
      chk($sformatf("d%0d_ready", d), {127'd0, ordy[d]}, {127'd0, model_ready(d)});
      chk($sformatf("d%0d_valid", d), {124'd0, ovld[d]}, {124'd0, ev});
      chk($sformatf("d%0d_data", d), odata[d], ed);
      chk($sformatf("d%0d_cmd", d), {112'd0, oc}, {112'd0, ec});
      chk($sformatf("d%0d_err", d), {127'd0, oerr[d]}, {127'd0, err_pend[d]});
    end
  endtask

  // Model the effect of one rising edge given the inputs held across it.
  task automatic model_edge();
    logic [3:0] m;
    bit         acc;
    if (rst) begin
      model_clear();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      m   = tmask(d, cmd_s[d]);
      acc = valid_s[d] && model_ready(d);
      for (int k = 0; k < 4; k++)
        if (mq[d*4+k].size() > 0 && rdy_s[d][k]) void'(mq[d*4+k].pop_front());
      if (acc)
        for (int k = 0; k < 4; k++)
          if (m[k]) mq[d*4+k].push_back({fwd(d, cmd_s[d]), data_s[d]});
      err_pend[d] = acc && (m == 4'b0000);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input int d, input bit en, input bit v, input logic [5:0] c,
                       input logic [31:0] dat, input logic [3:0] r);
    en_s[d] = en; valid_s[d] = v; cmd_s[d] = c; data_s[d] = dat; rdy_s[d] = r;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 6'd0, 32'd0, 4'b0000);
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_valid0", {124'd0, ovld[0]}, 128'd0);
    chk("rst_data1", odata[1], 128'd0);
    chk("rst_ready0", {127'd0, ordy[0]}, 128'd0);
    cycle();
    cycle();
    rst = 1'b0;

    // Binary tag 2: word appears on port 2 only, one cycle later.
    drive(0, 1'b1, 1'b1, 6'b10_0101, 32'h0000_00A5, 4'b0000);
    cycle();
    drive(0, 1'b1, 1'b0, 6'b00_0000, 32'd0, 4'b0000);
    chk("ex_bin_valid", {124'd0, ovld[0]}, {124'd0, 4'b0100});
    chk("ex_bin_data", {96'd0, odata[0][95:64]}, {96'd0, 32'hA5});
    chk("ex_bin_cmd", {124'd0, ocmd0[11:8]}, {124'd0, 4'b0101});
    drive(0, 1'b1, 1'b0, 6'd0, 32'd0, 4'b1111);
    cycle();

    // Mask 1011 multicast to ports 0,1,3.
    drive(1, 1'b1, 1'b1, 6'b1011_01, 32'h1234_5678, 4'b1111);
    cycle();
    drive(1, 1'b1, 1'b0, 6'd0, 32'd0, 4'b1111);
    chk("ex_mc_valid", {124'd0, ovld[1]}, {124'd0, 4'b1011});
    chk("ex_mc_cmd", {120'd0, ocmd1}, {120'd0, 8'b01_00_01_01});
    cycle();

    // Fill port 3, then a 1001 multicast must stall until port 3 drains.
    drive(1, 1'b1, 1'b1, 6'b1000_10, 32'hAAAA_0001, 4'b0111);
    cycle();
    drive(1, 1'b1, 1'b1, 6'b1000_11, 32'hAAAA_0002, 4'b0111);
    cycle();
    drive(1, 1'b1, 1'b1, 6'b1001_01, 32'hBBBB_0003, 4'b0111);
    cycle();
    chk("ex_stall_ready", {127'd0, ordy[1]}, 128'd0);
    chk("ex_stall_port0", {127'd0, ovld[1][0]}, 128'd0);
    drive(1, 1'b1, 1'b1, 6'b1001_01, 32'hBBBB_0003, 4'b1111);
    cycle();
    cycle();
    drive(1, 1'b1, 1'b0, 6'd0, 32'd0, 4'b1111);
    for (int i = 0; i < 3; i++) cycle();

    // Empty mask: accepted, discarded, error pulse.
    drive(1, 1'b1, 1'b1, 6'b0000_11, 32'hDEAD_BEEF, 4'b1111);
    cycle();
    drive(1, 1'b1, 1'b0, 6'd0, 32'd0, 4'b1111);
    chk("ex_discard_err", {127'd0, oerr[1]}, {127'd0, 1'b1});
    chk("ex_discard_valid", {124'd0, ovld[1]}, 128'd0);
    cycle();
    chk("ex_err_pulse_end", {127'd0, oerr[1]}, 128'd0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++)
        drive(d, ($urandom_range(7) != 0), $urandom_range(1),
              6'($urandom), $urandom, 4'($urandom));
      cycle();
    end

    // Stream three words to port 1 with it blocked, then reset mid-stream.
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 1'b0, 6'd0, 32'd0, 4'b1111);
    for (int i = 0; i < 4; i++) cycle();
    for (int w = 0; w < 3; w++) begin
      drive(0, 1'b1, 1'b1, 6'b01_0000 | 6'(w), 32'hC0 + 32'(w), 4'b0000);
      cycle();
    end
    chk("ex_third_stall", {127'd0, ordy[0]}, 128'd0);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("ex_rst_valid", {124'd0, ovld[0]}, 128'd0);
    chk("ex_rst_ready", {127'd0, ordy[0]}, 128'd0);
    cycle();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 6'b01_0000, 32'd0, 4'b0000);
    #1;
    chk("ex_post_rst_ready", {127'd0, ordy[0]}, {127'd0, 1'b1});
    drive(0, 1'b1, 1'b1, 6'b01_0111, 32'h0000_0777, 4'b0000);
    cycle();

    // Disabled switch: nothing accepted, buffered words still drain.
    drive(0, 1'b0, 1'b1, 6'b01_0001, 32'h0000_0888, 4'b0010);
    for (int i = 0; i < 3; i++) cycle();
    chk("ex_dis_drained", {124'd0, ovld[0]}, 128'd0);
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 6'd0, 32'd0, 4'b1111);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
